dual_issue_scheduler: RTL and testbench
=======================================

Name: dual_issue_scheduler

Overview:
- Hazard and issue sequencer for the two-lane decode-to-execute boundary.
- Each cycle it decides which decode lanes advance into execute, and which execute lanes are bubbled or flushed.
- Drives the per-lane enable/flush pair of the D/E register, plus the fetch/decode stall and flush controls.
- Splits dependent or structurally conflicting pairs over two cycles and keeps saturating hazard statistics.

Parameters:
CNT_W, 16, width of each saturating statistics counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
Rs1D, Rs2D, Rs4D, Rs5D  in  5 each  decode source regs (lane1: Rs1/Rs2, lane2: Rs4/Rs5)
RdD1, RdD2  in  5 each  decode destination regs
RegWriteD1, RegWriteD2  in  1 each  decode register-write
ResultSrcD1, ResultSrcD2  in  2 each  decode result select, 2'b01 = load
MemWriteD1, MemWriteD2  in  1 each  decode store
RdE1, RdE2  in  5 each  execute destination regs
ResultSrcE1, ResultSrcE2  in  2 each  execute result select, 2'b01 = load
PCSrcE1, PCSrcE2  in  1 each  taken branch/jump resolved in execute, per lane
StallF  out  1  hold PC
StallD  out  1  hold F/D register
FlushD  out  1  clear F/D register
en1, en2  out  1 each  D/E lane enables
rst1, rst2  out  1 each  D/E lane synchronous clears (bubble)
FlushM2  out  1  clear lane2 of E/M (younger than a taken lane1)
split_active  out  1  state == SPLIT
stall_cnt, split_cnt, flush_cnt  out  CNT_W each  statistics

Behaviour:
- State register, two states.
  - PAIR: the decode pair has not been issued.
  - SPLIT: lane1 has issued; lane2 is still held in decode.
- Reset (rst_n low, async):
  - State = PAIR; all counters = 0.
  - Outputs derived from reset state: StallF=StallD=FlushD=0, rst1=rst2=0, en1=en2=1, FlushM2=0, split_active=0.
- Control outputs are combinational from state and inputs. State and counters update on posedge clk.
- Dependency test: "reads X" = source equals X and X != 0.
- Hazard classes, highest priority first:
  1. Branch: PCSrcE1 or PCSrcE2.
     - FlushD=1, rst1=rst2=1, StallF=StallD=0.
     - FlushM2 = PCSrcE1 (lane2 in execute is younger than lane1).
     - Next state = PAIR. flush_cnt++.
  2. Load-use: an execute lane has ResultSrcE=01 with RegWrite-relevant RdE != 0, and any decode source of a lane still to issue reads it.
     - Lanes still to issue: both in PAIR, lane2 only in SPLIT.
     - StallF=StallD=1, rst1=rst2=1; state held. stall_cnt++.
  3. Split, PAIR state only. Triggered if lane2 reads RdD1 with RegWriteD1=1, or both lanes are memory ops (load or store).
     - en1=1, rst1=0, rst2=1, StallF=StallD=1.
     - Next state = SPLIT. split_cnt++.
  4. SPLIT state with no higher hazard:
     - rst1=1, en2=1, rst2=0, StallF=StallD=0.
     - Next state = PAIR.
  5. Otherwise: all pass, no stall, state PAIR.
- en1/en2 are 1 in every case; a bubble is expressed through rst1/rst2, which the D/E register honours over en.
- Counters saturate at all-ones; no wrap.
- Reset asserted mid-SPLIT: returns to PAIR. The held lane2 is discarded with decode by the top-level reset.
- Simultaneous PCSrcE1 and PCSrcE2: treated as one flush; flush_cnt increments by 1.

Test Plan:
- Independent pair (x5=x1+x2, x6=x3+x4) in PAIR → rst1=rst2=0, no stall; state stays PAIR; counters 0.
- Intra-pair RAW (lane1 writes x7, lane2 reads Rs4D=7) → cycle0: rst2=1, StallD=1, split_cnt=1; cycle1: rst1=1, rst2=0, no stall; state back to PAIR.
- Load-use: ResultSrcE1=01, RdE1=9, Rs2D=9 → StallF=StallD=1, rst1=rst2=1 for 1 cycle; stall_cnt=1. Repeat with RdE1=0 → no stall.
- PCSrcE1=1 while in SPLIT → FlushD=1, rst1=rst2=1, FlushM2=1; next state PAIR; flush_cnt=1. PCSrcE2 only → FlushM2=0.
- Two stores paired → split sequence as for RAW. Load-use on lane2 during SPLIT → stall with state held in SPLIT.
- Counter saturation with CNT_W=4: 20 load-use stalls → stall_cnt=15. Async rst_n pulse mid-cycle → counters 0 and split_active=0 immediately.

Source files
------------

// File: rtl/dual_issue_scheduler.sv
// Issue sequencer for the two-lane decode/execute boundary: resolves branch flushes,
// load-use stalls and intra-pair conflicts, and keeps saturating hazard statistics.
module dual_issue_scheduler #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs4D,
    input  logic [4:0]       Rs5D,
    input  logic [4:0]       RdD1,
    input  logic [4:0]       RdD2,
    input  logic             RegWriteD1,
    input  logic             RegWriteD2,
    input  logic [1:0]       ResultSrcD1,
    input  logic [1:0]       ResultSrcD2,
    input  logic             MemWriteD1,
    input  logic             MemWriteD2,
    input  logic [4:0]       RdE1,
    input  logic [4:0]       RdE2,
    input  logic [1:0]       ResultSrcE1,
    input  logic [1:0]       ResultSrcE2,
    input  logic             PCSrcE1,
    input  logic             PCSrcE2,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             en1,
    output logic             en2,
    output logic             rst1,
    output logic             rst2,
    output logic             FlushM2,
    output logic             split_active,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] split_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic {
        PAIR  = 1'b0,
        SPLIT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] split_cnt_q, split_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic branch, load_use, split_req;
    logic load_e1, load_e2, lane1_lu, lane2_lu;
    logic raw_pair, mem_pair;
    logic inc_stall, inc_split, inc_flush;

    // Lane2's destination never creates a hazard at this boundary.
    logic unused_lane2_dest;
    assign unused_lane2_dest = ^{RdD2, RegWriteD2};

    function automatic logic reads(input logic [4:0] src, input logic [4:0] x);
        return (x != 5'd0) && (src == x);
    endfunction

    assign load_e1 = (ResultSrcE1 == 2'b01) && (RdE1 != 5'd0);
    assign load_e2 = (ResultSrcE2 == 2'b01) && (RdE2 != 5'd0);

    assign lane1_lu = (load_e1 && (reads(Rs1D, RdE1) || reads(Rs2D, RdE1))) ||
                      (load_e2 && (reads(Rs1D, RdE2) || reads(Rs2D, RdE2)));
    assign lane2_lu = (load_e1 && (reads(Rs4D, RdE1) || reads(Rs5D, RdE1))) ||
                      (load_e2 && (reads(Rs4D, RdE2) || reads(Rs5D, RdE2)));

    // In SPLIT lane1 has already left decode, so only lane2's sources matter.
    assign load_use = lane2_lu || ((state_q == PAIR) && lane1_lu);

    assign raw_pair  = RegWriteD1 && (reads(Rs4D, RdD1) || reads(Rs5D, RdD1));
    assign mem_pair  = ((ResultSrcD1 == 2'b01) || MemWriteD1) &&
                       ((ResultSrcD2 == 2'b01) || MemWriteD2);
    assign split_req = (state_q == PAIR) && (raw_pair || mem_pair);
    assign branch    = PCSrcE1 || PCSrcE2;

    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        FlushD    = 1'b0;
        en1       = 1'b1;
        en2       = 1'b1;
        rst1      = 1'b0;
        rst2      = 1'b0;
        FlushM2   = 1'b0;
        state_d   = PAIR;
        inc_stall = 1'b0;
        inc_split = 1'b0;
        inc_flush = 1'b0;
        if (branch) begin
            FlushD    = 1'b1;
            rst1      = 1'b1;
            rst2      = 1'b1;
            FlushM2   = PCSrcE1;
            inc_flush = 1'b1;
        end else if (load_use) begin
            StallF    = 1'b1;
            StallD    = 1'b1;
            rst1      = 1'b1;
            rst2      = 1'b1;
            state_d   = state_q;
            inc_stall = 1'b1;
        end else if (split_req) begin
            StallF    = 1'b1;
            StallD    = 1'b1;
            rst2      = 1'b1;
            state_d   = SPLIT;
            inc_split = 1'b1;
        end else if (state_q == SPLIT) begin
            // Lane1 went last cycle; bubble its slot and let the held lane2 go.
            rst1 = 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        split_cnt_d = split_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (inc_stall && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + 1'b1;
        if (inc_split && (split_cnt_q != {CNT_W{1'b1}})) split_cnt_d = split_cnt_q + 1'b1;
        if (inc_flush && (flush_cnt_q != {CNT_W{1'b1}})) flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= PAIR;
            stall_cnt_q <= '0;
            split_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            split_cnt_q <= split_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign split_active = (state_q == SPLIT);
    assign stall_cnt    = stall_cnt_q;
    assign split_cnt    = split_cnt_q;
    assign flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Scenario bench for dual_issue_scheduler with 4-bit counters so saturation is reachable.
module tb_dual_issue_scheduler;

    localparam int CNT_W = 4;

    // Control vector: {StallF, StallD, FlushD, en1, en2, rst1, rst2, FlushM2, split_active}
    localparam logic [8:0] PASS_PAIR  = 9'b000_11_00_0_0;
    localparam logic [8:0] SPLIT_C0   = 9'b110_11_01_0_0;
    localparam logic [8:0] SPLIT_C1   = 9'b000_11_10_0_1;
    localparam logic [8:0] LU_PAIR    = 9'b110_11_11_0_0;
    localparam logic [8:0] LU_SPLIT   = 9'b110_11_11_0_1;
    localparam logic [8:0] BR1_SPLIT  = 9'b001_11_11_1_1;
    localparam logic [8:0] BR1_PAIR   = 9'b001_11_11_1_0;
    localparam logic [8:0] BR2_PAIR   = 9'b001_11_11_0_0;

    logic clk, rst_n;
    logic [4:0] Rs1D, Rs2D, Rs4D, Rs5D, RdD1, RdD2, RdE1, RdE2;
    logic RegWriteD1, RegWriteD2, MemWriteD1, MemWriteD2, PCSrcE1, PCSrcE2;
    logic [1:0] ResultSrcD1, ResultSrcD2, ResultSrcE1, ResultSrcE2;
    logic StallF, StallD, FlushD, en1, en2, rst1, rst2, FlushM2, split_active;
    logic [CNT_W-1:0] stall_cnt, split_cnt, flush_cnt;

    logic [8:0] ctrl;
    logic [8:0] exp_ctrl;
    logic [8:0] exp_q[$];
    logic [CNT_W-1:0] exp_stall, exp_split, exp_flush;
    int passed = 0;
    int total  = 0;

    assign ctrl = {StallF, StallD, FlushD, en1, en2, rst1, rst2, FlushM2, split_active};

    dual_issue_scheduler #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs4D(Rs4D), .Rs5D(Rs5D),
        .RdD1(RdD1), .RdD2(RdD2),
        .RegWriteD1(RegWriteD1), .RegWriteD2(RegWriteD2),
        .ResultSrcD1(ResultSrcD1), .ResultSrcD2(ResultSrcD2),
        .MemWriteD1(MemWriteD1), .MemWriteD2(MemWriteD2),
        .RdE1(RdE1), .RdE2(RdE2),
        .ResultSrcE1(ResultSrcE1), .ResultSrcE2(ResultSrcE2),
        .PCSrcE1(PCSrcE1), .PCSrcE2(PCSrcE2),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .en1(en1), .en2(en2), .rst1(rst1), .rst2(rst2),
        .FlushM2(FlushM2), .split_active(split_active),
        .stall_cnt(stall_cnt), .split_cnt(split_cnt), .flush_cnt(flush_cnt)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "timeout");
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    // Driver tasks
    task automatic clear_inputs();
        Rs1D = 0; Rs2D = 0; Rs4D = 0; Rs5D = 0; RdD1 = 0; RdD2 = 0;
        RegWriteD1 = 0; RegWriteD2 = 0; MemWriteD1 = 0; MemWriteD2 = 0;
        ResultSrcD1 = 0; ResultSrcD2 = 0; RdE1 = 0; RdE2 = 0;
        ResultSrcE1 = 0; ResultSrcE2 = 0; PCSrcE1 = 0; PCSrcE2 = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_raw_pair();
        clear_inputs();
        Rs1D = 1; Rs2D = 2; RdD1 = 7; RegWriteD1 = 1;
        Rs4D = 7; Rs5D = 3; RdD2 = 8; RegWriteD2 = 1;
    endtask

    // Scenarios
    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        exp_stall = 0; exp_split = 0; exp_flush = 0;
        exp_q.push_back(PASS_PAIR);
        #2;
        exp_ctrl = exp_q.pop_front(); total++;
        if (ctrl !== exp_ctrl) $display("FAIL reset_ctrl got=%b exp=%b", ctrl, exp_ctrl); else passed++;
        total++;
        if ({stall_cnt, split_cnt, flush_cnt} !== 12'h000)
            $display("FAIL reset_cnt got=%h exp=000", {stall_cnt, split_cnt, flush_cnt});
        else passed++;
        #1 rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_independent();
        clear_inputs();
        Rs1D = 1; Rs2D = 2; RdD1 = 5; RegWriteD1 = 1;
        Rs4D = 3; Rs5D = 4; RdD2 = 6; RegWriteD2 = 1;
        exp_q.push_back(PASS_PAIR);
        exp_q.push_back(PASS_PAIR);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            exp_ctrl = exp_q.pop_front(); total++;
            if (ctrl !== exp_ctrl) $display("FAIL indep_ctrl%0d got=%b exp=%b", i, ctrl, exp_ctrl); else passed++;
            next_cycle();
        end
        total++;
        if ({stall_cnt, split_cnt, flush_cnt} !== {exp_stall, exp_split, exp_flush})
            $display("FAIL indep_cnt got=%h exp=%h", {stall_cnt, split_cnt, flush_cnt}, {exp_stall, exp_split, exp_flush});
        else passed++;
    endtask

    task automatic test_raw_split();
        drive_raw_pair();
        exp_q.push_back(SPLIT_C0);
        exp_q.push_back(SPLIT_C1);
        exp_split = sat_inc(exp_split);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            exp_ctrl = exp_q.pop_front(); total++;
            if (ctrl !== exp_ctrl) $display("FAIL raw_c%0d got=%b exp=%b", i, ctrl, exp_ctrl); else passed++;
            next_cycle();
            if (i == 0) begin
                total++;
                if (split_cnt !== exp_split) $display("FAIL raw_split_cnt got=%0d exp=%0d", split_cnt, exp_split); else passed++;
            end
        end
        clear_inputs();
        exp_q.push_back(PASS_PAIR);
        @(negedge clk);
        exp_ctrl = exp_q.pop_front(); total++;
        if (ctrl !== exp_ctrl) $display("FAIL raw_back_pair got=%b exp=%b", ctrl, exp_ctrl); else passed++;
        next_cycle();
    endtask

    task automatic test_load_use();
        clear_inputs();
        ResultSrcE1 = 2'b01; RdE1 = 9; Rs2D = 9;
        exp_q.push_back(LU_PAIR);
        exp_stall = sat_inc(exp_stall);
        @(negedge clk);
        exp_ctrl = exp_q.pop_front(); total++;
        if (ctrl !== exp_ctrl) $display("FAIL lu_ctrl got=%b exp=%b", ctrl, exp_ctrl); else passed++;
        next_cycle();
        total++;
        if (stall_cnt !== exp_stall) $display("FAIL lu_stall_cnt got=%0d exp=%0d", stall_cnt, exp_stall); else passed++;
        RdE1 = 0; Rs2D = 0;
        exp_q.push_back(PASS_PAIR);
        @(negedge clk);
        exp_ctrl = exp_q.pop_front(); total++;
        if (ctrl !== exp_ctrl) $display("FAIL lu_x0_ctrl got=%b exp=%b", ctrl, exp_ctrl); else passed++;
        next_cycle();
        total++;
        if (stall_cnt !== exp_stall) $display("FAIL lu_x0_cnt got=%0d exp=%0d", stall_cnt, exp_stall); else passed++;
    endtask

    task automatic test_branch();
        drive_raw_pair();
        exp_split = sat_inc(exp_split);
        next_cycle();
        PCSrcE1 = 1;
        exp_q.push_back(BR1_SPLIT);
        exp_flush = sat_inc(exp_flush);
        @(negedge clk);
        exp_ctrl = exp_q.pop_front(); total++;
        if (ctrl !== exp_ctrl) $display("FAIL br1_ctrl got=%b exp=%b", ctrl, exp_ctrl); else passed++;
        next_cycle();
        total++;
        if ({split_active, flush_cnt} !== {1'b0, exp_flush})
            $display("FAIL br1_state got=%b/%0d exp=0/%0d", split_active, flush_cnt, exp_flush);
        else passed++;
        clear_inputs();
        PCSrcE2 = 1;
        exp_q.push_back(BR2_PAIR);
        exp_flush = sat_inc(exp_flush);
        @(negedge clk);
        exp_ctrl = exp_q.pop_front(); total++;
        if (ctrl !== exp_ctrl) $display("FAIL br2_ctrl got=%b exp=%b", ctrl, exp_ctrl); else passed++;
        next_cycle();
        PCSrcE1 = 1;
        exp_q.push_back(BR1_PAIR);
        exp_flush = sat_inc(exp_flush);
        @(negedge clk);
        exp_ctrl = exp_q.pop_front(); total++;
        if (ctrl !== exp_ctrl) $display("FAIL br_both_ctrl got=%b exp=%b", ctrl, exp_ctrl); else passed++;
        next_cycle();
        total++;
        if (flush_cnt !== exp_flush) $display("FAIL br_flush_cnt got=%0d exp=%0d", flush_cnt, exp_flush); else passed++;
        clear_inputs();
    endtask

    task automatic test_store_pair();
        clear_inputs();
        MemWriteD1 = 1; MemWriteD2 = 1; Rs1D = 1; Rs2D = 2; Rs4D = 12; Rs5D = 4;
        exp_q.push_back(SPLIT_C0);
        exp_split = sat_inc(exp_split);
        @(negedge clk);
        exp_ctrl = exp_q.pop_front(); total++;
        if (ctrl !== exp_ctrl) $display("FAIL st_c0 got=%b exp=%b", ctrl, exp_ctrl); else passed++;
        next_cycle();
        ResultSrcE2 = 2'b01; RdE2 = 12;
        exp_q.push_back(LU_SPLIT);
        exp_stall = sat_inc(exp_stall);
        @(negedge clk);
        exp_ctrl = exp_q.pop_front(); total++;
        if (ctrl !== exp_ctrl) $display("FAIL st_lu_split got=%b exp=%b", ctrl, exp_ctrl); else passed++;
        next_cycle();
        // A load feeding only lane1 no longer matters once lane1 has issued.
        ResultSrcE2 = 0; RdE2 = 0; ResultSrcE1 = 2'b01; RdE1 = 1;
        exp_q.push_back(SPLIT_C1);
        @(negedge clk);
        exp_ctrl = exp_q.pop_front(); total++;
        if (ctrl !== exp_ctrl) $display("FAIL st_c1 got=%b exp=%b", ctrl, exp_ctrl); else passed++;
        next_cycle();
        total++;
        if ({split_active, stall_cnt, split_cnt} !== {1'b0, exp_stall, exp_split})
            $display("FAIL st_end got=%b/%0d/%0d exp=0/%0d/%0d", split_active, stall_cnt, split_cnt, exp_stall, exp_split);
        else passed++;
        clear_inputs();
    endtask

    task automatic test_random_load_use();
        int r, which, lane;
        for (int i = 0; i < 6; i++) begin
            clear_inputs();
            r = $urandom_range(1, 31);
            which = $urandom_range(0, 3);
            lane = $urandom_range(0, 1);
            case (which)
                0: Rs1D = r[4:0];
                1: Rs2D = r[4:0];
                2: Rs4D = r[4:0];
                default: Rs5D = r[4:0];
            endcase
            if (lane == 0) begin
                ResultSrcE1 = 2'b01; RdE1 = r[4:0]; RdE2 = 5'($urandom_range(0, 31));
            end else begin
                ResultSrcE2 = 2'b01; RdE2 = r[4:0]; RdE1 = 5'($urandom_range(0, 31));
            end
            exp_q.push_back(LU_PAIR);
            exp_stall = sat_inc(exp_stall);
            @(negedge clk);
            exp_ctrl = exp_q.pop_front(); total++;
            if (ctrl !== exp_ctrl)
                $display("FAIL rnd_lu%0d r=%0d src=%0d lane=%0d got=%b exp=%b", i, r, which, lane, ctrl, exp_ctrl);
            else passed++;
            next_cycle();
        end
        clear_inputs();
    endtask

    task automatic test_saturation();
        clear_inputs();
        ResultSrcE1 = 2'b01; RdE1 = 9; Rs2D = 9;
        for (int i = 0; i < 20; i++) begin
            exp_q.push_back(LU_PAIR);
            exp_stall = sat_inc(exp_stall);
            @(negedge clk);
            exp_ctrl = exp_q.pop_front(); total++;
            if (ctrl !== exp_ctrl) $display("FAIL sat_ctrl%0d got=%b exp=%b", i, ctrl, exp_ctrl); else passed++;
            next_cycle();
            total++;
            if (stall_cnt !== exp_stall) $display("FAIL sat_cnt%0d got=%0d exp=%0d", i, stall_cnt, exp_stall); else passed++;
        end
        total++;
        if (stall_cnt !== 4'hf) $display("FAIL sat_final got=%0d exp=15", stall_cnt); else passed++;
        clear_inputs();
    endtask

    task automatic test_async_reset();
        drive_raw_pair();
        next_cycle();
        clear_inputs();
        #2 rst_n = 1'b0;
        exp_stall = 0; exp_split = 0; exp_flush = 0;
        exp_q.push_back(PASS_PAIR);
        #1;
        exp_ctrl = exp_q.pop_front(); total++;
        if (ctrl !== exp_ctrl) $display("FAIL areset_ctrl got=%b exp=%b", ctrl, exp_ctrl); else passed++;
        total++;
        if ({stall_cnt, split_cnt, flush_cnt} !== {exp_stall, exp_split, exp_flush})
            $display("FAIL areset_cnt got=%h exp=000", {stall_cnt, split_cnt, flush_cnt});
        else passed++;
        #3 rst_n = 1'b1;
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_independent();
        test_raw_split();
        test_load_use();
        test_branch();
        test_store_pair();
        test_random_load_use();
        test_saturation();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
